impact_sram_access_ctrl: RTL and testbench
==========================================

Name: impact_sram_access_ctrl

Overview:
Sequencer that sits directly upstream of the IMPACT SRAM head and drives its array pins: 32 word lines (East), 32 bit lines (West) and 32 complement bit lines (South). It takes one word-level read or write request at a time through a valid/ready handshake. For each request it runs precharge, word-line pulse, sense and recovery phases, then returns read data with a per-bit fault flag. Bidirectional bit-line pads are split into out/oe/in triplets; the pad tristate sits in the top-level wrapper.

Parameters:
PRE_CYC, 2, precharge cycles (legal range 1..255)
WL_CYC, 3, word-line active cycles (legal range 1..255)
CNT_W, 8, phase counter width

Ports:
wb_clk_i  in  1  sole clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
req_valid  in  1  request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  5  word-line index 0..31
req_wdata  in  32  write data
wl  out  32  one-hot word lines, to East[31:0]
bl_out  out  32  bit-line drive value, to West
bl_oe  out  32  bit-line drive enable
bl_in  in  32  bit-line sensed value, from West
blb_out  out  32  complement bit-line drive value, to South
blb_oe  out  32  complement drive enable
blb_in  in  32  complement sensed value, from South
rdata  out  32  read data
rfault  out  32  per-bit fault: bl_in[i] == blb_in[i] at sample
rvalid  out  1  one-cycle pulse, rdata/rfault valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, async): state=IDLE, cnt=0.
  - wl, bl_out, bl_oe, blb_out, blb_oe, rdata, rfault = 0; rvalid=0; busy=0.
  - req_ready deasserts immediately with reset.
  - Reset mid-operation drops wl and all oe to 0 at once. The aborted request is lost; no rvalid is produced.
- All outputs are registered except req_ready, which is combinational: high iff state==IDLE and rst_n high.
- Handshake: request is accepted on the rising edge where req_valid && req_ready. On accept, addr/we/wdata are latched. Later changes on req_* are ignored until the next IDLE.
- States:
  - IDLE
    - wl=0, all oe=0.
    - On accept -> PRE with cnt=PRE_CYC-1.
  - PRE
    - bl_out=blb_out=all ones; bl_oe=blb_oe=all ones; wl=0.
    - Decrement cnt. At cnt==0 -> WL with cnt=WL_CYC-1.
  - WL, write
    - wl = 1<<addr.
    - bl_out=wdata, blb_out=~wdata, both oe=all ones.
  - WL, read
    - wl = 1<<addr; both oe=0, so bit lines float from the precharge level.
  - WL exit
    - Decrement cnt. At cnt==0 -> REC.
    - For reads, on the edge leaving WL: rdata<=bl_in and rfault<=~(bl_in ^ blb_in).
  - REC
    - wl=0, all oe=0 (bit-line drive values are don't-care; they are held at 0).
    - Reads: rvalid=1 for exactly this cycle.
    - Writes: rvalid stays 0, and rdata/rfault hold their previous values.
    - REC -> IDLE unconditionally.
- Timing relative to the accept edge, cycle 0 = first PRE cycle:
  - PRE occupies PRE_CYC cycles.
  - WL occupies WL_CYC cycles.
  - REC occupies 1 cycle.
  - req_ready returns after PRE_CYC+WL_CYC+1 cycles (6 at defaults).
- Back-to-back: if req_valid is held, the next request is accepted on the first IDLE cycle. Minimum request period is PRE_CYC+WL_CYC+2 cycles.
- wl is never multi-hot and never asserted while any oe is asserted during PRE.
- wl changes only at phase boundaries. No glitching is allowed: wl is driven directly from flops.
- Addr 0 and 31 are ordinary; no wrap or out-of-range case exists (5-bit index).
- rdata/rfault hold their value until the next read sample.

Test Plan:
- Reset: rst_n low mid-WL of a write to addr 7 -> wl=0, bl_oe=blb_oe=0 within the same cycle (async); after release, req_ready=1 and rvalid never pulses.
- Write at defaults, addr=5, wdata=0xA5A5_0F0F -> 2 cycles with bl_out=blb_out=0xFFFF_FFFF and oe=0xFFFF_FFFF; then 3 cycles with wl=0x0000_0020, bl_out=0xA5A5_0F0F, blb_out=0x5A5A_F0F0; then REC with wl=0 and rvalid=0; req_ready high 6 cycles after accept.
- Read, addr=31, bench drives bl_in=0x1234_5678, blb_in=0xEDCB_A987 -> wl=0x8000_0000 for 3 cycles with oe=0; rvalid pulses once with rdata=0x1234_5678 and rfault=0.
- Fault detect: read addr=0 with bl_in=0xFFFF_0000, blb_in=0xFFFF_FFFF -> wl=0x0000_0001; rdata=0xFFFF_0000, rfault=0xFFFF_0000.
- Back-to-back: req_valid held high with a write to addr 3 then a read from addr 3 -> second accept exactly one cycle after REC; request period 7 cycles; req_* changes during busy are ignored.
- Parameter corner: PRE_CYC=1, WL_CYC=1 -> one PRE cycle, one WL cycle, one REC cycle; read sample is taken on the single WL cycle; wl is one-hot throughout.

Source files
------------

// File: rtl/impact_sram_access_ctrl.sv
// Word-level read/write sequencer for the IMPACT SRAM array pins.
// Each request runs precharge, word-line pulse, sense and recovery phases.
module impact_sram_access_ctrl #(
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 3,
    parameter int CNT_W   = 8
) (
    input  logic        wb_clk_i,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] wl,
    output logic [31:0] bl_out,
    output logic [31:0] bl_oe,
    input  logic [31:0] bl_in,
    output logic [31:0] blb_out,
    output logic [31:0] blb_oe,
    input  logic [31:0] blb_in,
    output logic [31:0] rdata,
    output logic [31:0] rfault,
    output logic        rvalid,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        WLA  = 2'd2,
        REC  = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              we_r;
    logic [4:0]        addr_r;
    logic [31:0]       wdata_r;
    logic              accept_s;
    logic              sample_s;
    logic [31:0]       wl_s, bl_out_s, bl_oe_s, blb_out_s, blb_oe_s;
    logic              rvalid_s, busy_s;

    function automatic logic [31:0] wl_decode(input logic [4:0] a);
        wl_decode = 32'd1 << a;
    endfunction

    // Ready is combinational so reset withdraws it without waiting for a clock.
    assign req_ready = (state_r == IDLE) && rst_n;

    // Next-state and phase counter.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        sample_s = 1'b0;
        accept_s = req_valid && (state_r == IDLE);
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = PRE;
                    cnt_s   = CNT_W'(PRE_CYC - 1);
                end else begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end
            end
            PRE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = WLA;
                    cnt_s   = CNT_W'(WL_CYC - 1);
                end else begin
                    cnt_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            WLA: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s  = REC;
                    sample_s = ~we_r;
                end else begin
                    cnt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            REC: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Pin values for the state being entered, so every pin comes straight from a flop.
    always_comb begin
        wl_s      = 32'd0;
        bl_out_s  = 32'd0;
        bl_oe_s   = 32'd0;
        blb_out_s = 32'd0;
        blb_oe_s  = 32'd0;
        rvalid_s  = 1'b0;
        busy_s    = (state_s != IDLE);
        case (state_s)
            PRE: begin
                bl_out_s  = 32'hFFFF_FFFF;
                blb_out_s = 32'hFFFF_FFFF;
                bl_oe_s   = 32'hFFFF_FFFF;
                blb_oe_s  = 32'hFFFF_FFFF;
            end
            WLA: begin
                wl_s = wl_decode(addr_r);
                if (we_r) begin
                    bl_out_s  = wdata_r;
                    blb_out_s = ~wdata_r;
                    bl_oe_s   = 32'hFFFF_FFFF;
                    blb_oe_s  = 32'hFFFF_FFFF;
                end else begin
                    bl_oe_s   = 32'd0;
                    blb_oe_s  = 32'd0;
                end
            end
            REC: begin
                rvalid_s = ~we_r;
            end
            default: begin
                rvalid_s = 1'b0;
            end
        endcase
    end

    // State, latched request and registered pins.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            addr_r  <= 5'd0;
            wdata_r <= 32'd0;
            wl      <= 32'd0;
            bl_out  <= 32'd0;
            bl_oe   <= 32'd0;
            blb_out <= 32'd0;
            blb_oe  <= 32'd0;
            rdata   <= 32'd0;
            rfault  <= 32'd0;
            rvalid  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                we_r    <= req_we;
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
            end
            if (sample_s) begin
                rdata  <= bl_in;
                rfault <= ~(bl_in ^ blb_in);
            end
            wl      <= wl_s;
            bl_out  <= bl_out_s;
            bl_oe   <= bl_oe_s;
            blb_out <= blb_out_s;
            blb_oe  <= blb_oe_s;
            rvalid  <= rvalid_s;
            busy    <= busy_s;
        end
    end

endmodule

// File: tb/tb_impact_sram_access_ctrl.sv
// Scoreboard bench: instance 0 at default timing, instance 1 at PRE_CYC=WL_CYC=1.
module tb_impact_sram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [4:0]  req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [31:0] bl_in     [2];
    logic [31:0] blb_in    [2];
    logic        rand_bl   [2];
    logic        req_ready [2];
    logic [31:0] wl_o      [2];
    logic [31:0] bl_out_o  [2];
    logic [31:0] bl_oe_o   [2];
    logic [31:0] blb_out_o [2];
    logic [31:0] blb_oe_o  [2];
    logic [31:0] rdata_o   [2];
    logic [31:0] rfault_o  [2];
    logic        rvalid_o  [2];
    logic        busy_o    [2];

    logic [63:0] sbq [2][$];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    impact_sram_access_ctrl u_dut0 (
        .wb_clk_i(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .wl(wl_o[0]), .bl_out(bl_out_o[0]), .bl_oe(bl_oe_o[0]), .bl_in(bl_in[0]),
        .blb_out(blb_out_o[0]), .blb_oe(blb_oe_o[0]), .blb_in(blb_in[0]),
        .rdata(rdata_o[0]), .rfault(rfault_o[0]), .rvalid(rvalid_o[0]), .busy(busy_o[0])
    );

    impact_sram_access_ctrl #(.PRE_CYC(1), .WL_CYC(1), .CNT_W(8)) u_dut1 (
        .wb_clk_i(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .wl(wl_o[1]), .bl_out(bl_out_o[1]), .bl_oe(bl_oe_o[1]), .bl_in(bl_in[1]),
        .blb_out(blb_out_o[1]), .blb_oe(blb_oe_o[1]), .blb_in(blb_in[1]),
        .rdata(rdata_o[1]), .rfault(rfault_o[1]), .rvalid(rvalid_o[1]), .busy(busy_o[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Present a request and wait for it to be taken; without hold the fields are scrambled afterwards.
    task automatic issue(input int g, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic hold);
        int n = 0;
        req_valid[g] = 1'b1;
        req_we[g]    = we;
        req_addr[g]  = a;
        req_wdata[g] = d;
        while (n < 200) begin
            @(negedge clk);
            if (req_ready[g]) break;
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL accept_timeout: dut %0d never ready after %0d cycles", g, n);
        end
        @(posedge clk); #1;
        if (!hold) begin
            req_valid[g] = 1'b0;
            req_we[g]    = 1'($urandom);
            req_addr[g]  = 5'($urandom);
            req_wdata[g] = $urandom;
        end
    endtask

    task automatic wait_idle(input int g);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (req_ready[g]) break;
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL idle_timeout: dut %0d busy for %0d cycles", g, n);
        end
        @(posedge clk); #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_mon
        localparam int P = (g == 0) ? 2 : 1;
        localparam int W = (g == 0) ? 3 : 1;
        int          k = 0;
        int          cyc = 0;
        int          last_acc = 0;
        bit          act = 1'b0;
        bit          held = 1'b0;
        logic        awe;
        logic [4:0]  aad;
        logic [31:0] awd;
        logic [31:0] last_rd = 32'd0;
        logic [31:0] last_rf = 32'd0;

        // Random sense values every cycle, so the sample point is exercised.
        always @(posedge clk) begin
            #1;
            if (rand_bl[g]) begin
                bl_in[g]  = $urandom;
                blb_in[g] = ($urandom_range(0, 1) == 0) ? ~bl_in[g] : $urandom;
            end
        end

        // Cycle model: expected pins from the number of cycles since accept.
        always @(negedge clk) begin
            cyc++;
            if (!rst_n) begin
                act = 1'b0;
                held = 1'b0;
                last_rd = 32'd0;
                last_rf = 32'd0;
                sbq[g].delete();
                chk("rst_wl", wl_o[g], 32'd0);
                chk("rst_bl_oe", bl_oe_o[g], 32'd0);
                chk("rst_blb_oe", blb_oe_o[g], 32'd0);
                chk("rst_ready", {31'd0, req_ready[g]}, 32'd0);
                chk("rst_rvalid", {31'd0, rvalid_o[g]}, 32'd0);
                chk("rst_busy", {31'd0, busy_o[g]}, 32'd0);
                chk("rst_rdata", rdata_o[g], 32'd0);
            end else begin
                chk("busy", {31'd0, busy_o[g]}, {31'd0, act});
                chk("ready", {31'd0, req_ready[g]}, {31'd0, !act});
                if (act) begin
                    if (k < P) begin
                        chk("pre_wl", wl_o[g], 32'd0);
                        chk("pre_bl_out", bl_out_o[g], 32'hFFFF_FFFF);
                        chk("pre_blb_out", blb_out_o[g], 32'hFFFF_FFFF);
                        chk("pre_bl_oe", bl_oe_o[g], 32'hFFFF_FFFF);
                        chk("pre_blb_oe", blb_oe_o[g], 32'hFFFF_FFFF);
                        chk("pre_rvalid", {31'd0, rvalid_o[g]}, 32'd0);
                    end else if (k < P + W) begin
                        chk("wl_onehot", wl_o[g], 32'd1 << aad);
                        chk("wl_rvalid", {31'd0, rvalid_o[g]}, 32'd0);
                        if (awe) begin
                            chk("wr_bl_out", bl_out_o[g], awd);
                            chk("wr_blb_out", blb_out_o[g], ~awd);
                            chk("wr_bl_oe", bl_oe_o[g], 32'hFFFF_FFFF);
                            chk("wr_blb_oe", blb_oe_o[g], 32'hFFFF_FFFF);
                        end else begin
                            chk("rd_bl_oe", bl_oe_o[g], 32'd0);
                            chk("rd_blb_oe", blb_oe_o[g], 32'd0);
                            if (k == P + W - 1) begin
                                last_rd = bl_in[g];
                                last_rf = ~(bl_in[g] ^ blb_in[g]);
                                sbq[g].push_back({last_rd, last_rf});
                            end
                        end
                    end else begin
                        chk("rec_wl", wl_o[g], 32'd0);
                        chk("rec_bl_oe", bl_oe_o[g], 32'd0);
                        chk("rec_blb_oe", blb_oe_o[g], 32'd0);
                        chk("rec_rvalid", {31'd0, rvalid_o[g]}, {31'd0, !awe});
                        if (awe) begin
                            chk("wr_rdata_hold", rdata_o[g], last_rd);
                            chk("wr_rfault_hold", rfault_o[g], last_rf);
                        end
                    end
                    k++;
                    if (k == P + W + 1) act = 1'b0;
                end else begin
                    chk("idle_wl", wl_o[g], 32'd0);
                    chk("idle_oe", bl_oe_o[g] | blb_oe_o[g], 32'd0);
                    chk("idle_rvalid", {31'd0, rvalid_o[g]}, 32'd0);
                    chk("idle_rdata_hold", rdata_o[g], last_rd);
                end
                if (!req_valid[g]) held = 1'b0;
                if (!act && req_valid[g] && req_ready[g]) begin
                    if (held) chk("b2b_period", 32'(cyc - last_acc), 32'(P + W + 2));
                    last_acc = cyc;
                    held = 1'b1;
                    act = 1'b1;
                    k = 0;
                    awe = req_we[g];
                    aad = req_addr[g];
                    awd = req_wdata[g];
                end
            end
        end

        // Scoreboard: every rvalid pulse must match the oldest expected read.
        always @(negedge clk) begin
            logic [63:0] e;
            if (rst_n && rvalid_o[g]) begin
                if (sbq[g].size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_rvalid: dut %0d rdata %h with no read pending", g, rdata_o[g]);
                end else begin
                    e = sbq[g].pop_front();
                    chk("rdata", rdata_o[g], e[63:32]);
                    chk("rfault", rfault_o[g], e[31:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0; req_we[g] = 1'b0; req_addr[g] = 5'd0;
            req_wdata[g] = 32'd0; bl_in[g] = 32'd0; blb_in[g] = 32'd0; rand_bl[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(0, 1'b1, 5'd5, 32'hA5A5_0F0F, 1'b0);
        wait_idle(0);

        rand_bl[0] = 1'b0;
        bl_in[0] = 32'h1234_5678; blb_in[0] = 32'hEDCB_A987;
        issue(0, 1'b0, 5'd31, 32'd0, 1'b0);
        wait_idle(0);
        bl_in[0] = 32'hFFFF_0000; blb_in[0] = 32'hFFFF_FFFF;
        issue(0, 1'b0, 5'd0, 32'd0, 1'b0);
        wait_idle(0);
        rand_bl[0] = 1'b1;

        issue(0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b1);
        issue(0, 1'b0, 5'd3, 32'h0, 1'b0);
        wait_idle(0);

        // Reset in the middle of a write's word-line phase.
        issue(0, 1'b1, 5'd7, 32'h0F0F_F0F0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_wl", wl_o[0], 32'd0);
        chk("async_rst_bl_oe", bl_oe_o[0], 32'd0);
        chk("async_rst_blb_oe", blb_oe_o[0], 32'd0);
        chk("async_rst_ready", {31'd0, req_ready[0]}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            int g;
            g = i % 2;
            issue(g, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 2) != 0));
        end
        for (int g = 0; g < 2; g++) begin
            req_valid[g] = 1'b0;
            wait_idle(g);
        end
        repeat (4) @(posedge clk);
        #1;
        chk("sbq0_empty", 32'(sbq[0].size()), 32'd0);
        chk("sbq1_empty", 32'(sbq[1].size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
